strait_test_controller: RTL and testbench

//  Sequences the STRAIT self-test: steps the eNVM pattern store through all SA patterns, then TD launch/capture pairs.
//  Per pattern, handshakes with the systolic array to apply the scan data and collect per-PE mismatch flags, then ORs them into a fault map.

---
 rtl/strait_test_controller_pkg.sv | 23 ++
 rtl/strait_test_controller_fault_diag.sv | 28 ++
 rtl/strait_test_controller.sv | 205 ++++++++++++++++++++
 tb/tb_strait_test_controller.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strait_test_controller_pkg.sv
// Shared types and helpers for the STRAIT self-test controller.
// State encoding and pattern/pass-count arithmetic.
package strait_test_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_APPLY = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DIAG  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Every TD pattern needs a launch and a capture pass.
    function automatic int unsigned pass_count(int unsigned sa, int unsigned td);
        return sa + 2 * td;
    endfunction

    function automatic int unsigned max_depth(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/strait_test_controller_fault_diag.sv
// Combinational fault classification for an N x N PE fault map.
// Full rows/columns are flagged; remaining isolated PEs become single faults.
module strait_test_controller_fault_diag
    import strait_test_controller_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N*N-1:0]        fault_map_i,
    output logic [N-1:0]          row_f_o,
    output logic [N-1:0]          col_f_o,
    output logic [N-1:0][N-1:0]   single_o
);

    // AND-reduce rows and columns, then mask out PEs already covered by them.
    always_comb begin
        row_f_o  = '0;
        col_f_o  = '1;
        single_o = '0;
        for (int r = 0; r < N; r++) begin
            row_f_o[r] = &fault_map_i[r*N +: N];
            col_f_o    = col_f_o & fault_map_i[r*N +: N];
        end
        for (int r = 0; r < N; r++) begin
            single_o[r] = fault_map_i[r*N +: N] & ~col_f_o & ~{N{row_f_o[r]}};
        end
    end

endmodule

// File: rtl/strait_test_controller.sv
// STRAIT self-test sequencer: walks SA then TD launch/capture patterns,
// accumulates per-PE mismatches and writes the classified fault map to eNVM.
module strait_test_controller
    import strait_test_controller_pkg::*;
#(
    parameter int SYSTOLIC_SIZE          = 8,
    parameter int ADDR_WIDTH             = $clog2(SYSTOLIC_SIZE),
    parameter int SA_TEST_PATTERN_DEPTH  = 12,
    parameter int TD_TEST_PATTERN_DEPTH  = 18,
    parameter int MAX_PATTERN_ADDR_WIDTH =
        $clog2(max_depth(SA_TEST_PATTERN_DEPTH, TD_TEST_PATTERN_DEPTH)),
    parameter int TIMEOUT_CYCLES         = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              any_fault,
    output logic                              timeout_err,
    output logic                              test_type,
    output logic                              TD_answer_choose,
    output logic [MAX_PATTERN_ADDR_WIDTH-1:0] test_counter,
    output logic                              apply_valid,
    input  logic                              array_done,
    input  logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] pe_mismatch,
    output logic                              detection_en,
    output logic [ADDR_WIDTH-1:0]             detection_addr,
    output logic [SYSTOLIC_SIZE-1:0]          single_pe_detection,
    output logic                              row_fault_detection,
    output logic                              column_fault_detection
);

    localparam int N  = SYSTOLIC_SIZE;
    localparam int CW = MAX_PATTERN_ADDR_WIDTH;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]         SA_LAST  = CW'(SA_TEST_PATTERN_DEPTH - 1);
    localparam logic [CW-1:0]         TD_LAST  = CW'(TD_TEST_PATTERN_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(N - 1);

    state_t                 state_q, state_d;
    logic [N*N-1:0]         fault_map_q, fault_map_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   type_q, type_d;
    logic                   choose_q, choose_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0]  wr_row_q, wr_row_d;
    logic [N-1:0]           row_f_q, row_f_d;
    logic [N-1:0]           col_f_q, col_f_d;
    logic [N-1:0][N-1:0]    single_q, single_d;

    logic [N-1:0]           diag_row;
    logic [N-1:0]           diag_col;
    logic [N-1:0][N-1:0]    diag_single;
    logic                   advance;

    strait_test_controller_fault_diag #(
        .N (N)
    ) u_diag (
        .fault_map_i (fault_map_q),
        .row_f_o     (diag_row),
        .col_f_o     (diag_col),
        .single_o    (diag_single)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fault_map_q   <= '0;
            timeout_err_q <= 1'b0;
            type_q        <= 1'b0;
            choose_q      <= 1'b0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            wr_row_q      <= '0;
            row_f_q       <= '0;
            col_f_q       <= '0;
            single_q      <= '0;
        end else begin
            state_q       <= state_d;
            fault_map_q   <= fault_map_d;
            timeout_err_q <= timeout_err_d;
            type_q        <= type_d;
            choose_q      <= choose_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            wr_row_q      <= wr_row_d;
            row_f_q       <= row_f_d;
            col_f_q       <= col_f_d;
            single_q      <= single_d;
        end
    end

    // Next-state: pattern sequencing, fault accumulation and write-out.
    always_comb begin
        state_d       = state_q;
        fault_map_d   = fault_map_q;
        timeout_err_d = timeout_err_q;
        type_d        = type_q;
        choose_d      = choose_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        wr_row_d      = wr_row_q;
        row_f_d       = row_f_q;
        col_f_d       = col_f_q;
        single_d      = single_q;
        advance       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    fault_map_d   = '0;
                    timeout_err_d = 1'b0;
                    type_d        = 1'b0;
                    choose_d      = 1'b0;
                    cnt_d         = '0;
                    state_d       = ST_APPLY;
                end
            end
            ST_APPLY: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (array_done) begin
                    fault_map_d = fault_map_q | pe_mismatch;
                    advance     = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    fault_map_d   = '1;
                    timeout_err_d = 1'b1;
                    advance       = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
                if (advance) begin
                    state_d = ST_APPLY;
                    if (!type_q) begin
                        if (cnt_q < SA_LAST) begin
                            cnt_d = cnt_q + 1'b1;
                        end else begin
                            type_d   = 1'b1;
                            cnt_d    = '0;
                            choose_d = 1'b0;
                        end
                    end else if (!choose_q) begin
                        choose_d = 1'b1;
                    end else if (cnt_q < TD_LAST) begin
                        cnt_d    = cnt_q + 1'b1;
                        choose_d = 1'b0;
                    end else begin
                        state_d = ST_DIAG;
                    end
                end
            end
            ST_DIAG: begin
                row_f_d  = diag_row;
                col_f_d  = diag_col;
                single_d = diag_single;
                wr_row_d = '0;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                if (wr_row_q == ROW_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    wr_row_d = wr_row_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Decoded outputs; detection data is held at zero outside write strobes.
    always_comb begin
        busy                   = (state_q != ST_IDLE);
        done                   = (state_q == ST_DONE);
        apply_valid            = (state_q == ST_APPLY);
        detection_en           = (state_q == ST_WRITE);
        any_fault              = |fault_map_q;
        timeout_err            = timeout_err_q;
        test_type              = type_q;
        TD_answer_choose       = choose_q;
        test_counter           = cnt_q;
        detection_addr         = '0;
        single_pe_detection    = '0;
        row_fault_detection    = 1'b0;
        column_fault_detection = 1'b0;
        if (detection_en) begin
            detection_addr         = wr_row_q;
            single_pe_detection    = single_q[wr_row_q];
            row_fault_detection    = row_f_q[wr_row_q];
            column_fault_detection = col_f_q[wr_row_q];
        end
    end

endmodule

// File: tb/tb_strait_test_controller.sv
// Scoreboard bench for strait_test_controller.
// Models the array responder and predicts pass order and fault rows.
module tb_strait_test_controller;
    import strait_test_controller_pkg::*;

    localparam int N   = 8;
    localparam int SA  = 12;
    localparam int TD  = 18;
    localparam int AW  = 3;
    localparam int PW  = 5;
    localparam int TMO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy, done, any_fault, timeout_err;
    logic            test_type, TD_answer_choose;
    logic [PW-1:0]   test_counter;
    logic            apply_valid;
    logic            array_done;
    logic [N*N-1:0]  pe_mismatch;
    logic            detection_en;
    logic [AW-1:0]   detection_addr;
    logic [N-1:0]    single_pe_detection;
    logic            row_fault_detection, column_fault_detection;

    strait_test_controller dut (
        .clk                    (clk),
        .rst                    (rst),
        .start                  (start),
        .busy                   (busy),
        .done                   (done),
        .any_fault              (any_fault),
        .timeout_err            (timeout_err),
        .test_type              (test_type),
        .TD_answer_choose       (TD_answer_choose),
        .test_counter           (test_counter),
        .apply_valid            (apply_valid),
        .array_done             (array_done),
        .pe_mismatch            (pe_mismatch),
        .detection_en           (detection_en),
        .detection_addr         (detection_addr),
        .single_pe_detection    (single_pe_detection),
        .row_fault_detection    (row_fault_detection),
        .column_fault_detection (column_fault_detection)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [6:0]  sb_seq[$];
    logic [12:0] sb_wr[$];

    int          scen;
    int          cyc = 0;
    int          n_apply, n_writes;
    int          to_apply_cyc, to_set_cyc;
    bit          to_seen, done_seen;
    logic [7:0]  obs_single[8];
    bit          obs_row[8];
    bit          obs_col[8];
    logic        exp_any, exp_tmo;

    function automatic logic [63:0] inj(int s, bit t, int c, bit ch);
        if (s == 3 && !t && c == 5 && !ch) return 64'd1 << 19;
        if (s == 4 && !t && c == 0)
            return 64'h0000_0000_FF00_0000 | 64'h4040_4040_4040_4040;
        return 64'd0;
    endfunction

    function automatic bit withhold(int s, bit t, int c, bit ch);
        return (s == 5 && t && c == 4 && ch);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Array model: answers each apply_valid two cycles later.
    initial begin
        bit rt;
        int rc;
        bit rch;
        array_done  = 1'b0;
        pe_mismatch = '0;
        forever begin
            @(negedge clk);
            if (apply_valid && !rst) begin
                rt  = test_type;
                rc  = int'(test_counter);
                rch = TD_answer_choose;
                @(posedge clk);
                @(posedge clk);
                #1;
                if (!withhold(scen, rt, rc, rch)) begin
                    array_done  = 1'b1;
                    pe_mismatch = inj(scen, rt, rc, rch);
                    @(posedge clk);
                    #1;
                    array_done  = 1'b0;
                    pe_mismatch = '0;
                end
            end
        end
    end

    // Output monitor: pops scoreboards on apply and write strobes.
    always @(negedge clk) begin
        if (!rst) begin
            if (apply_valid) begin
                n_apply++;
                if (sb_seq.size() == 0)
                    check("seq_extra", 1, 0);
                else
                    check("seq", {test_type, test_counter, TD_answer_choose},
                          sb_seq.pop_front());
                if (scen == 5 && test_type && test_counter == 4 &&
                    TD_answer_choose)
                    to_apply_cyc = cyc;
            end
            if (detection_en) begin
                n_writes++;
                obs_single[detection_addr] = single_pe_detection;
                obs_row[detection_addr]    = row_fault_detection;
                obs_col[detection_addr]    = column_fault_detection;
                if (sb_wr.size() == 0)
                    check("wr_extra", 1, 0);
                else
                    check("wr", {detection_addr, single_pe_detection,
                                 row_fault_detection, column_fault_detection},
                          sb_wr.pop_front());
            end
            if (timeout_err && !to_seen) begin
                to_seen    = 1'b1;
                to_set_cyc = cyc;
            end
            if (done) done_seen = 1'b1;
        end
    end

    task automatic push_expect(input int s);
        logic [63:0] fm;
        logic [7:0]  rowv, colv, sg;
        fm      = '0;
        exp_tmo = 1'b0;
        sb_seq.delete();
        sb_wr.delete();
        for (int k = 0; k < SA; k++) begin
            sb_seq.push_back({1'b0, PW'(k), 1'b0});
            fm |= inj(s, 1'b0, k, 1'b0);
        end
        for (int k = 0; k < TD; k++) begin
            for (int ch = 0; ch < 2; ch++) begin
                sb_seq.push_back({1'b1, PW'(k), 1'(ch)});
                if (withhold(s, 1'b1, k, 1'(ch))) begin
                    fm      = '1;
                    exp_tmo = 1'b1;
                end else begin
                    fm |= inj(s, 1'b1, k, 1'(ch));
                end
            end
        end
        exp_any = |fm;
        colv    = 8'hFF;
        for (int r = 0; r < N; r++) begin
            rowv[r] = &fm[r*N +: N];
            colv    = colv & fm[r*N +: N];
        end
        for (int r = 0; r < N; r++) begin
            sg = fm[r*N +: N] & ~colv & ~{8{rowv[r]}};
            sb_wr.push_back({AW'(r), sg, rowv[r], colv[r]});
        end
    endtask

    task automatic kick(input int s);
        scen      = s;
        push_expect(s);
        to_seen   = 1'b0;
        done_seen = 1'b0;
        n_apply   = 0;
        n_writes  = 0;
        for (int r = 0; r < N; r++) begin
            obs_single[r] = '0;
            obs_row[r]    = 1'b0;
            obs_col[r]    = 1'b0;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("flags_cleared", {any_fault, timeout_err}, 2'b00);
    endtask

    task automatic finish_run(input string tag);
        for (int i = 0; i < 6000 && !done_seen; i++) @(negedge clk);
        check({tag, "_done"}, done_seen, 1);
        @(negedge clk);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_passes"}, n_apply, pass_count(SA, TD));
        check({tag, "_writes"}, n_writes, N);
        check({tag, "_sb_empty"}, sb_seq.size() + sb_wr.size(), 0);
        check({tag, "_any_fault"}, any_fault, exp_any);
        check({tag, "_timeout"}, timeout_err, exp_tmo);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        scen  = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_outputs",
              {busy, done, apply_valid, detection_en, any_fault,
               timeout_err, test_type, TD_answer_choose}, 0);
        check("rst_counter", test_counter, 0);
        check("rst_det", {detection_addr, single_pe_detection,
                          row_fault_detection, column_fault_detection}, 0);

        kick(1);
        finish_run("nofault");

        kick(3);
        finish_run("single");
        check("single_row2", obs_single[2], 8'h08);
        for (int r = 0; r < N; r++)
            if (r != 2) check("single_other", obs_single[r], 8'h00);

        kick(4);
        finish_run("rowcol");
        check("row3_flag", obs_row[3], 1);
        check("col6_flag", obs_col[6], 1);
        for (int r = 0; r < N; r++) begin
            check("rowcol_single", obs_single[r], 8'h00);
            if (r != 3) check("rowcol_row", obs_row[r], 0);
            if (r != 6) check("rowcol_col", obs_col[r], 0);
        end

        kick(5);
        finish_run("timeout");
        check("timeout_latency", to_set_cyc - to_apply_cyc, TMO + 1);
        for (int r = 0; r < N; r++) begin
            check("timeout_row", obs_row[r], 1);
            check("timeout_col", obs_col[r], 1);
        end

        kick(1);
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 6000 && !hit; i++) begin
                @(negedge clk);
                #1;
                if (detection_en && detection_addr == 3'd4) hit = 1'b1;
            end
            check("reach_wr4", hit, 1);
        end
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_det", detection_en, 0);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_rows", n_writes, 5);
        sb_wr.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_quiet", {busy, detection_en}, 0);
        end
        kick(1);
        finish_run("restart");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
